// File: rtl/any1_bht_update_ctrl.sv
// any1_bht_update_ctrl
// Sequences every write into the gselect BHT. After reset or a reinit pulse it sweeps
// all entries to INIT_VAL. In RUN it queues branch resolutions from two commit ports in
// program order and drains one per cycle onto the predictor's single update port.
// Optional build macro: ANY1_BHT_UPD_STATS_EN adds saturating stat_upd/stat_kill counters.

module any1_bht_update_ctrl #(
  parameter int unsigned AWID       = 32,
  parameter int unsigned TBL_DEPTH  = 512,
  parameter logic [1:0]  INIT_VAL   = 2'd3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reinit,
  input  logic                         c0_v,
  input  logic [AWID-1:0]              c0_ip,
  input  logic                         c0_takb,
  input  logic                         c1_v,
  input  logic [AWID-1:0]              c1_ip,
  input  logic                         c1_takb,
  output logic                         c_rdy,
  output logic                         upd_v,
  output logic [AWID-1:0]              upd_ip,
  output logic                         upd_takb,
  output logic                         init_we,
  output logic [$clog2(TBL_DEPTH)-1:0] init_addr,
  output logic [1:0]                   init_data,
  output logic                         pred_en
`ifdef ANY1_BHT_UPD_STATS_EN
  ,
  output logic [31:0]                  stat_upd,
  output logic [31:0]                  stat_kill
`endif
);

  localparam int unsigned TAW = $clog2(TBL_DEPTH);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;

  localparam logic [TAW-1:0] AddrLast = TAW'(TBL_DEPTH - 1);
  localparam logic [CW-1:0]  CntDepth = CW'(FIFO_DEPTH);

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  logic           state_q, state_d;
  // Cleared only by rst so the cycle right after reset shows all-zero outputs;
  // the sweep begins on the following cycle.
  logic           armed_q;
  logic [TAW-1:0] init_addr_q, init_addr_d;

  logic [AWID-1:0] mem_ip   [FIFO_DEPTH];
  logic            mem_takb [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            c_rdy_q, c_rdy_d;
  logic            upd_v_q, upd_v_d;
  logic [AWID-1:0] upd_ip_q, upd_ip_d;
  logic            upd_takb_q, upd_takb_d;

  logic       accept;
  logic       kill;
  logic       enq0;
  logic       enq1;
  logic       deq;
  logic [1:0] n_enq;

  // Enqueue/dequeue decisions for this cycle
  always_comb begin
    accept = (state_q == StRun) && c_rdy_q && !reinit;
    kill   = c0_v && c0_takb;
    enq0   = accept && c0_v;
    enq1   = accept && c1_v && !kill;
    n_enq  = {1'b0, enq0} + {1'b0, enq1};
    deq    = (state_q == StRun) && !reinit && (cnt_q != '0);
  end

  // Next-state for FSM, sweep address, queue pointers and registered outputs
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    wr_ptr_d    = wr_ptr_q + PW'(n_enq);
    rd_ptr_d    = rd_ptr_q + PW'(deq);
    cnt_d       = cnt_q + CW'(n_enq) - CW'(deq);
    upd_v_d     = deq;
    upd_ip_d    = mem_ip[rd_ptr_q];
    upd_takb_d  = mem_takb[rd_ptr_q];

    case (state_q)
      StInit: begin
        if (armed_q) begin
          init_addr_d = init_addr_q + TAW'(1);
          if (init_addr_q == AddrLast) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase

    // reinit restarts the sweep and throws away everything queued or in flight
    if (reinit) begin
      state_d     = StInit;
      init_addr_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      upd_v_d     = 1'b0;
    end

    if (!upd_v_d) begin
      upd_ip_d   = '0;
      upd_takb_d = 1'b0;
    end

    // Two free slots after this edge guarantee the next pair can never overflow
    c_rdy_d = (state_d == StRun) && ((CntDepth - cnt_d) >= CW'(2));
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      armed_q     <= 1'b0;
      init_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      c_rdy_q     <= 1'b0;
      upd_v_q     <= 1'b0;
      upd_ip_q    <= '0;
      upd_takb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      init_addr_q <= init_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      c_rdy_q     <= c_rdy_d;
      upd_v_q     <= upd_v_d;
      upd_ip_q    <= upd_ip_d;
      upd_takb_q  <= upd_takb_d;
    end
  end

  // Queue storage; c0 lands first, c1 behind it (or alone when c0 is idle)
  always_ff @(posedge clk) begin
    if (enq0 || enq1) begin
      mem_ip[wr_ptr_q]   <= enq0 ? c0_ip : c1_ip;
      mem_takb[wr_ptr_q] <= enq0 ? c0_takb : c1_takb;
    end
    if (enq0 && enq1) begin
      mem_ip[wr_ptr_q + PW'(1)]   <= c1_ip;
      mem_takb[wr_ptr_q + PW'(1)] <= c1_takb;
    end
  end

`ifdef ANY1_BHT_UPD_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_kill_q;

  // Saturating event counters; survive reinit, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_upd_q  <= '0;
      stat_kill_q <= '0;
    end else begin
      if (upd_v_q && (stat_upd_q != 32'hFFFF_FFFF)) begin
        stat_upd_q <= stat_upd_q + 32'd1;
      end
      if (accept && c1_v && kill && (stat_kill_q != 32'hFFFF_FFFF)) begin
        stat_kill_q <= stat_kill_q + 32'd1;
      end
    end
  end

  assign stat_upd  = stat_upd_q;
  assign stat_kill = stat_kill_q;
`endif

  assign c_rdy     = c_rdy_q;
  assign upd_v     = upd_v_q;
  assign upd_ip    = upd_ip_q;
  assign upd_takb  = upd_takb_q;
  assign init_we   = (state_q == StInit) && armed_q;
  assign init_addr = init_addr_q;
  assign init_data = INIT_VAL;
  assign pred_en   = (state_q == StRun);

endmodule

// File: tb/tb_any1_bht_update_ctrl.sv
// Directed bench for any1_bht_update_ctrl (AWID=32, TBL_DEPTH=512, FIFO_DEPTH=4).

module tb_any1_bht_update_ctrl;

  logic        clk;
  logic        rst;
  logic        reinit;
  logic        c0_v;
  logic [31:0] c0_ip;
  logic        c0_takb;
  logic        c1_v;
  logic [31:0] c1_ip;
  logic        c1_takb;
  logic        c_rdy;
  logic        upd_v;
  logic [31:0] upd_ip;
  logic        upd_takb;
  logic        init_we;
  logic [8:0]  init_addr;
  logic [1:0]  init_data;
  logic        pred_en;
`ifdef ANY1_BHT_UPD_STATS_EN
  logic [31:0] stat_upd;
  logic [31:0] stat_kill;
`endif

  int checks;
  int failures;

  any1_bht_update_ctrl #(
    .AWID       (32),
    .TBL_DEPTH  (512),
    .INIT_VAL   (2'd3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reinit    (reinit),
    .c0_v      (c0_v),
    .c0_ip     (c0_ip),
    .c0_takb   (c0_takb),
    .c1_v      (c1_v),
    .c1_ip     (c1_ip),
    .c1_takb   (c1_takb),
    .c_rdy     (c_rdy),
    .upd_v     (upd_v),
    .upd_ip    (upd_ip),
    .upd_takb  (upd_takb),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .pred_en   (pred_en)
`ifdef ANY1_BHT_UPD_STATS_EN
    ,
    .stat_upd  (stat_upd),
    .stat_kill (stat_kill)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c0_v = 0; c0_ip = '0; c0_takb = 0;
    c1_v = 0; c1_ip = '0; c1_takb = 0;
  endtask

  // Walks a sweep that is already writing address 0; no judgement made here
  task automatic measure_sweep(output int len, output int addr_errs, output int bad_seen);
    len = 0; addr_errs = 0; bad_seen = 0;
    while (init_we === 1'b1 && len < 1000) begin
      if (init_addr !== 9'(len)) addr_errs++;
      if (upd_v !== 1'b0 || c_rdy !== 1'b0 || pred_en !== 1'b0) bad_seen++;
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1; reinit = 0; idle_inputs();
    tick();
    tick();
    checks++; if (init_we !== 1'b0) begin failures++; $display("FAIL reset_init_we got=%0b want=0", init_we); end
    checks++; if (init_addr !== 9'd0) begin failures++; $display("FAIL reset_init_addr got=%0d want=0", init_addr); end
    checks++; if (init_data !== 2'd3) begin failures++; $display("FAIL reset_init_data got=%0d want=3", init_data); end
    checks++; if (pred_en !== 1'b0) begin failures++; $display("FAIL reset_pred_en got=%0b want=0", pred_en); end
    checks++; if (c_rdy !== 1'b0) begin failures++; $display("FAIL reset_c_rdy got=%0b want=0", c_rdy); end
    checks++; if (upd_v !== 1'b0) begin failures++; $display("FAIL reset_upd_v got=%0b want=0", upd_v); end
`ifdef ANY1_BHT_UPD_STATS_EN
    checks++; if (stat_upd !== 32'd0 || stat_kill !== 32'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_upd, stat_kill); end
`endif
    rst = 0;
  endtask

  task automatic test_init_sweep();
    int n, len, errs, bad;
    n = 0;
    while (init_we !== 1'b1 && n < 8) begin tick(); n++; end
    checks++; if (init_we !== 1'b1 || init_addr !== 9'd0) begin failures++; $display("FAIL sweep_start got=%0b@%0d want=1@0", init_we, init_addr); end
    measure_sweep(len, errs, bad);
    checks++; if (len !== 512) begin failures++; $display("FAIL sweep_len got=%0d want=512", len); end
    checks++; if (errs !== 0) begin failures++; $display("FAIL sweep_addr_seq got=%0d bad want=0", errs); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL sweep_gating got=%0d bad want=0", bad); end
    checks++; if (pred_en !== 1'b1 || c_rdy !== 1'b1) begin failures++; $display("FAIL run_entry got=%0b/%0b want=1/1", pred_en, c_rdy); end
  endtask

  task automatic test_pair_order();
    c0_v = 1; c0_ip = 32'h100; c0_takb = 0;
    c1_v = 1; c1_ip = 32'h104; c1_takb = 1;
    tick();
    idle_inputs();
    checks++; if (upd_v !== 1'b0) begin failures++; $display("FAIL pair_latency got=%0b want=0", upd_v); end
    tick();
    checks++; if ({upd_v, upd_takb, upd_ip} !== {2'b10, 32'h100}) begin failures++; $display("FAIL pair_first got=%0b/%0b/%0h want=1/0/100", upd_v, upd_takb, upd_ip); end
    tick();
    checks++; if ({upd_v, upd_takb, upd_ip} !== {2'b11, 32'h104}) begin failures++; $display("FAIL pair_second got=%0b/%0b/%0h want=1/1/104", upd_v, upd_takb, upd_ip); end
    tick();
    checks++; if (upd_v !== 1'b0) begin failures++; $display("FAIL pair_end got=%0b want=0", upd_v); end
  endtask

  task automatic test_taken_kill();
    c0_v = 1; c0_ip = 32'h200; c0_takb = 1;
    c1_v = 1; c1_ip = 32'h208; c1_takb = 0;
    tick();
    idle_inputs();
    tick();
    checks++; if ({upd_v, upd_takb, upd_ip} !== {2'b11, 32'h200}) begin failures++; $display("FAIL kill_c0 got=%0b/%0b/%0h want=1/1/200", upd_v, upd_takb, upd_ip); end
    tick();
    checks++; if (upd_v !== 1'b0) begin failures++; $display("FAIL kill_c1_dropped got=%0b/%0h want=0", upd_v, upd_ip); end
    // c1 alone still enqueues
    c1_v = 1; c1_ip = 32'h300; c1_takb = 1;
    tick();
    idle_inputs();
    tick();
    checks++; if ({upd_v, upd_takb, upd_ip} !== {2'b11, 32'h300}) begin failures++; $display("FAIL c1_alone got=%0b/%0b/%0h want=1/1/300", upd_v, upd_takb, upd_ip); end
    tick();
    checks++; if (upd_v !== 1'b0) begin failures++; $display("FAIL c1_alone_end got=%0b want=0", upd_v); end
`ifdef ANY1_BHT_UPD_STATS_EN
    checks++; if (stat_upd !== 32'd4) begin failures++; $display("FAIL stat_upd got=%0d want=4", stat_upd); end
    checks++; if (stat_kill !== 32'd1) begin failures++; $display("FAIL stat_kill got=%0d want=1", stat_kill); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [32:0] q[$];
    logic [32:0] e;
    logic        exp_rdy, exp_v, acc;
    int          emitted, bad_rdy, bad_out;
    exp_rdy = 1; emitted = 0; bad_rdy = 0; bad_out = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 8) begin
        c0_v = 1; c0_ip = 32'h1000 + 32'(cyc * 16);     c0_takb = 0;
        c1_v = 1; c1_ip = 32'h1000 + 32'(cyc * 16 + 4); c1_takb = cyc[0];
      end else begin
        idle_inputs();
      end
      if (c_rdy !== exp_rdy) bad_rdy++;
      acc = exp_rdy && (cyc < 8);
      tick();
      exp_v = 0; e = '0;
      if (q.size() > 0) begin exp_v = 1; e = q.pop_front(); end
      if (acc) begin
        q.push_back({1'b0, 32'h1000 + 32'(cyc * 16)});
        q.push_back({cyc[0], 32'h1000 + 32'(cyc * 16 + 4)});
      end
      exp_rdy = (4 - q.size()) >= 2;
      if (upd_v !== exp_v) bad_out++;
      else if (exp_v && {upd_takb, upd_ip} !== e) bad_out++;
      if (upd_v === 1'b1) emitted++;
    end
    idle_inputs();
    checks++; if (bad_rdy !== 0) begin failures++; $display("FAIL b2b_c_rdy got=%0d bad want=0", bad_rdy); end
    checks++; if (bad_out !== 0) begin failures++; $display("FAIL b2b_order got=%0d bad want=0", bad_out); end
    checks++; if (emitted !== 10) begin failures++; $display("FAIL b2b_count got=%0d want=10", emitted); end
  endtask

  task automatic test_reinit_flush();
    int len, errs, bad, leak;
    c0_v = 1; c0_ip = 32'h500; c0_takb = 0;
    c1_v = 1; c1_ip = 32'h504; c1_takb = 1;
    tick();
    checks++; if (c_rdy !== 1'b1) begin failures++; $display("FAIL flush_rdy got=%0b want=1", c_rdy); end
    c0_ip = 32'h600; c1_ip = 32'h604;
    tick();
    idle_inputs();
    checks++; if ({upd_v, upd_ip} !== {1'b1, 32'h500}) begin failures++; $display("FAIL flush_inflight got=%0b/%0h want=1/500", upd_v, upd_ip); end
    reinit = 1;
    tick();
    reinit = 0;
    checks++; if (init_we !== 1'b1 || init_addr !== 9'd0) begin failures++; $display("FAIL flush_init got=%0b@%0d want=1@0", init_we, init_addr); end
    checks++; if (upd_v !== 1'b0 || pred_en !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0b/%0b want=0/0", upd_v, pred_en); end
    measure_sweep(len, errs, bad);
    checks++; if (len !== 512 || errs !== 0 || bad !== 0) begin failures++; $display("FAIL flush_sweep got=%0d/%0d/%0d want=512/0/0", len, errs, bad); end
    leak = 0;
    for (int i = 0; i < 6; i++) begin
      if (upd_v !== 1'b0) leak++;
      tick();
    end
    checks++; if (leak !== 0) begin failures++; $display("FAIL flush_leak got=%0d want=0", leak); end
    checks++; if (pred_en !== 1'b1 || c_rdy !== 1'b1) begin failures++; $display("FAIL flush_run got=%0b/%0b want=1/1", pred_en, c_rdy); end
  endtask

  task automatic test_rst_mid_init();
    int n, len, errs, bad;
    reinit = 1;
    tick();
    reinit = 0;
    n = 0;
    while (init_addr !== 9'd200 && n < 400) begin tick(); n++; end
    checks++; if (init_addr !== 9'd200) begin failures++; $display("FAIL mid_reach got=%0d want=200", init_addr); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (init_we !== 1'b0 || init_addr !== 9'd0 || pred_en !== 1'b0) begin failures++; $display("FAIL mid_rst got=%0b@%0d/%0b want=0@0/0", init_we, init_addr, pred_en); end
`ifdef ANY1_BHT_UPD_STATS_EN
    checks++; if (stat_upd !== 32'd0 || stat_kill !== 32'd0) begin failures++; $display("FAIL mid_stats got=%0d/%0d want=0/0", stat_upd, stat_kill); end
`endif
    tick();
    checks++; if (init_we !== 1'b1 || init_addr !== 9'd0) begin failures++; $display("FAIL mid_restart got=%0b@%0d want=1@0", init_we, init_addr); end
    measure_sweep(len, errs, bad);
    checks++; if (len !== 512 || errs !== 0) begin failures++; $display("FAIL mid_sweep got=%0d/%0d want=512/0", len, errs); end
    checks++; if (pred_en !== 1'b1) begin failures++; $display("FAIL mid_run got=%0b want=1", pred_en); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; reinit = 0; idle_inputs();
    test_reset();
    test_init_sweep();
    test_pair_order();
    test_taken_kill();
    test_back_to_back();
    test_reinit_flush();
    test_rst_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
